core_dmem_arbiter: RTL and testbench

//   Shares the single D-mem port between N requesters: core MEM stage (idx 0), MMU page-table

---
 rtl/core_pkg.sv | 13 +
 rtl/core_rr_pick.sv | 41 ++++
 rtl/core_dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_core_dmem_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the core memory-side arbiters.
package core_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_LOCKED
    } arb_state_e;

    localparam int DMEM_REQ_CORE = 0;
    localparam int DMEM_REQ_PTW  = 1;

endpackage

// File: rtl/core_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping to index 0.
module core_rr_pick
    import core_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt_oh,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] masked;
    logic [N-1:0] cand;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign hi_mask[gi] = (ptr <= IDX_W'(gi));
        end
    endgenerate

    // Prefer requests at or above the pointer; fall back to the lowest one (wrap).
    assign masked = req & hi_mask;
    assign cand   = (|masked) ? masked : req;
    assign gnt_oh = cand & (~cand + N'(1));
    assign any    = |req;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_oh[i]) begin
                gnt_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/core_dmem_arbiter.sv
// Round-robin D-mem port arbiter with grant hold until completion and owner lock for LR/SC/AMO.
module core_dmem_arbiter
    import core_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*32-1:0]   req_addr,
    input  logic [N_REQ-1:0]      req_write,
    input  logic [N_REQ*32-1:0]   req_wdata,
    input  logic [N_REQ*4-1:0]    req_wstrb,
    input  logic [N_REQ-1:0]      req_lock,
    output logic [31:0]           req_rdata,
    output logic [N_REQ-1:0]      req_err,
    output logic                  dmem_valid,
    input  logic                  dmem_ready,
    output logic [31:0]           dmem_addr,
    output logic                  dmem_write,
    output logic [31:0]           dmem_wdata,
    output logic [3:0]            dmem_wstrb,
    input  logic [31:0]           dmem_rdata,
    input  logic                  dmem_err,
    output logic [IDX_W-1:0]      gnt_idx
);

    arb_state_e       state_reg, state_next;
    logic [IDX_W-1:0] owner_reg, owner_next;
    logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;

    logic [N_REQ-1:0] pick_oh, owner_oh, gnt_oh, gnt_live;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any, pick_lock, owner_valid, owner_lock;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    core_rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_reg),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_owner
            assign owner_oh[gi] = (owner_reg == IDX_W'(gi));
        end
    endgenerate

    assign owner_valid = |(owner_oh & req_valid);
    assign owner_lock  = |(owner_oh & req_lock);
    assign pick_lock   = |(pick_oh & req_lock);

    // Idle follows the live pick for zero added latency; otherwise the mux is frozen on the owner.
    assign gnt_oh     = (state_reg == ARB_IDLE) ? pick_oh : owner_oh;
    assign gnt_live   = gnt_oh & req_valid & {N_REQ{rst_n}};
    assign dmem_valid = |gnt_live;
    assign req_ready  = gnt_live & {N_REQ{dmem_ready}};
    assign req_err    = req_ready & {N_REQ{dmem_err}};
    assign req_rdata  = dmem_rdata;
    assign gnt_idx    = (state_reg == ARB_IDLE) ? pick_idx : owner_reg;

    always_comb begin
        dmem_addr  = '0;
        dmem_write = 1'b0;
        dmem_wdata = '0;
        dmem_wstrb = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_live[i]) begin
                dmem_addr  = dmem_addr  | req_addr[i*32 +: 32];
                dmem_write = dmem_write | req_write[i];
                dmem_wdata = dmem_wdata | req_wdata[i*32 +: 32];
                dmem_wstrb = dmem_wstrb | req_wstrb[i*4 +: 4];
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (pick_any) begin
                    if (!dmem_ready) begin
                        state_next = ARB_BUSY;
                        owner_next = pick_idx;
                    end else if (pick_lock) begin
                        state_next = ARB_LOCKED;
                        owner_next = pick_idx;
                    end else begin
                        rr_ptr_next = wrap_inc(pick_idx);
                    end
                end
            end
            ARB_BUSY: begin
                // A vanished owner is a protocol error: drop it without consuming its turn.
                if (!owner_valid) begin
                    state_next = ARB_IDLE;
                end else if (dmem_ready) begin
                    if (owner_lock) begin
                        state_next = ARB_LOCKED;
                    end else begin
                        state_next  = ARB_IDLE;
                        rr_ptr_next = wrap_inc(owner_reg);
                    end
                end
            end
            ARB_LOCKED: begin
                if (owner_valid) begin
                    if (!dmem_ready) begin
                        state_next = ARB_BUSY;
                    end else if (!owner_lock) begin
                        state_next  = ARB_IDLE;
                        rr_ptr_next = wrap_inc(owner_reg);
                    end
                end else if (!owner_lock) begin
                    state_next  = ARB_IDLE;
                    rr_ptr_next = wrap_inc(owner_reg);
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ARB_IDLE;
            owner_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    a_owner_holds_valid: assert property (
        @(posedge clk) disable iff (!rst_n) (state_reg == ARB_BUSY) |-> owner_valid
    );

endmodule

// File: tb/tb_core_dmem_arbiter.sv
// Bench for core_dmem_arbiter: directed vector table, hand sequences, then randomized traffic vs a model.
module tb_core_dmem_arbiter;

    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid, req_ready, req_write, req_lock, req_err;
    logic [NR*32-1:0] req_addr, req_wdata;
    logic [NR*4-1:0] req_wstrb;
    logic [31:0]     req_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic            dmem_valid, dmem_ready, dmem_write, dmem_err;
    logic [3:0]      dmem_wstrb;
    logic [0:0]      gnt_idx;

    int n_checks = 0;
    int n_fail   = 0;

    core_dmem_arbiter #(.N_REQ(NR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .req_lock   (req_lock),
        .req_rdata  (req_rdata),
        .req_err    (req_err),
        .dmem_valid (dmem_valid),
        .dmem_ready (dmem_ready),
        .dmem_addr  (dmem_addr),
        .dmem_write (dmem_write),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .dmem_rdata (dmem_rdata),
        .dmem_err   (dmem_err),
        .gnt_idx    (gnt_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Fixed payloads for the directed phase.
    localparam logic [31:0] A0 = 32'h0000_0100, A1 = 32'h0000_0200;
    localparam logic [31:0] W0 = 32'hAAAA_0000, W1 = 32'h5555_1111;
    localparam logic [3:0]  S0 = 4'hF, S1 = 4'h3;

    typedef struct packed {
        logic [1:0] valid;
        logic [1:0] lock;
        logic       rdy;
        logic       err;
        logic       e_dv;
        logic [1:0] e_rdy;
        logic [1:0] e_err;
        logic       e_gnt;
    } vec_t;

    vec_t tbl [0:16];

    task automatic drive(input logic [1:0] v, input logic [1:0] lk, input logic rdy, input logic err);
        req_valid  = v;
        req_lock   = lk;
        dmem_ready = rdy;
        dmem_err   = err;
        dmem_rdata = $urandom;
    endtask

    task automatic check_fixed(input string tag, input logic e_dv, input logic [1:0] e_rdy,
                               input logic [1:0] e_err, input logic e_gnt);
        check({tag, ".dmem_valid"}, 64'(dmem_valid), 64'(e_dv));
        check({tag, ".req_ready"},  64'(req_ready),  64'(e_rdy));
        check({tag, ".req_err"},    64'(req_err),    64'(e_err));
        check({tag, ".dmem_addr"},  64'(dmem_addr),  64'(e_dv ? (e_gnt ? A1 : A0) : 32'h0));
        check({tag, ".dmem_wdata"}, 64'(dmem_wdata), 64'(e_dv ? (e_gnt ? W1 : W0) : 32'h0));
        check({tag, ".dmem_wstrb"}, 64'(dmem_wstrb), 64'(e_dv ? (e_gnt ? S1 : S0) : 4'h0));
        check({tag, ".dmem_write"}, 64'(dmem_write), 64'(e_dv & e_gnt));
        if (e_dv) check({tag, ".gnt_idx"}, 64'(gnt_idx), 64'(e_gnt));
    endtask

    // Behavioural reference: who owns the port (-1 = nobody) and whose turn it is next.
    int m_owner, m_ptr;

    function automatic int model_sel(input logic [NR-1:0] v);
        if (m_owner >= 0) return m_owner;
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_ptr + k) % NR;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    logic [31:0] p_addr [NR];
    logic [31:0] p_wdata [NR];
    logic [3:0]  p_wstrb [NR];
    logic        p_write [NR];
    logic        pend [NR];
    logic        lockr [NR];

    initial begin
        logic [31:0] tmp, e_addr, e_wdata, rd;
        logic [3:0]  e_wstrb;
        logic [1:0]  e_rdy, e_err;
        logic        e_dv, e_wr;
        int          sel;

        tbl[0]  = '{2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0};
        tbl[1]  = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1};
        tbl[2]  = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0};
        tbl[3]  = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1};
        tbl[4]  = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0};
        tbl[5]  = '{2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1};
        tbl[6]  = '{2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
        tbl[7]  = '{2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1};
        tbl[8]  = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0};
        tbl[9]  = '{2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0};
        tbl[10] = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0};
        tbl[11] = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1};
        tbl[12] = '{2'b11, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0};
        tbl[13] = '{2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        tbl[14] = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0};
        tbl[15] = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1};
        tbl[16] = '{2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0};

        req_addr  = {A1, A0};
        req_wdata = {W1, W0};
        req_wstrb = {S1, S0};
        req_write = 2'b10;

        // Reset with live-looking inputs: everything toward requesters and memory must stay quiet.
        rst_n = 1'b0;
        drive(2'b11, 2'b00, 1'b1, 1'b1);
        #1;
        check("reset.dmem_valid", 64'(dmem_valid), 64'd0);
        check("reset.req_ready",  64'(req_ready),  64'd0);
        check("reset.req_err",    64'(req_err),    64'd0);
        check("reset.dmem_addr",  64'(dmem_addr),  64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(2'b00, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        check("idle.gnt_idx", 64'(gnt_idx), 64'd0);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(tbl[i].valid, tbl[i].lock, tbl[i].rdy, tbl[i].err);
            rd = dmem_rdata;
            #1;
            check_fixed($sformatf("vec%0d", i), tbl[i].e_dv, tbl[i].e_rdy, tbl[i].e_err, tbl[i].e_gnt);
            check($sformatf("vec%0d.req_rdata", i), 64'(req_rdata), 64'(rd));
            $display("vec %0d: valid=%b lock=%b ready=%b -> dmem_valid=%b req_ready=%b req_err=%b gnt=%0d",
                     i, tbl[i].valid, tbl[i].lock, tbl[i].rdy, dmem_valid, req_ready, req_err, gnt_idx);
        end

        // Hold: owner 1 waits three cycles while requester 0 arrives; 0 wins right after.
        @(negedge clk); drive(2'b10, 2'b00, 1'b0, 1'b0); #1; check_fixed("hold0", 1'b1, 2'b00, 2'b00, 1'b1);
        @(negedge clk); drive(2'b11, 2'b00, 1'b0, 1'b0); #1; check_fixed("hold1", 1'b1, 2'b00, 2'b00, 1'b1);
        @(negedge clk); drive(2'b11, 2'b00, 1'b0, 1'b0); #1; check_fixed("hold2", 1'b1, 2'b00, 2'b00, 1'b1);
        @(negedge clk); drive(2'b11, 2'b00, 1'b1, 1'b0); #1; check_fixed("hold3", 1'b1, 2'b10, 2'b00, 1'b1);
        @(negedge clk); drive(2'b01, 2'b00, 1'b1, 1'b0); #1; check_fixed("hold4", 1'b1, 2'b01, 2'b00, 1'b0);
        $display("txn hold sequence done");

        // Reset mid-BUSY with owner 1 locked; afterwards requester 0 must win the tie.
        @(negedge clk); drive(2'b10, 2'b10, 1'b0, 1'b0); #1; check_fixed("rstbusy0", 1'b1, 2'b00, 2'b00, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        drive(2'b10, 2'b10, 1'b1, 1'b1);
        #1;
        check("rstbusy.dmem_valid", 64'(dmem_valid), 64'd0);
        check("rstbusy.req_ready",  64'(req_ready),  64'd0);
        check("rstbusy.req_err",    64'(req_err),    64'd0);
        @(negedge clk); drive(2'b00, 2'b00, 1'b0, 1'b0); rst_n = 1'b1;
        @(negedge clk); drive(2'b11, 2'b00, 1'b1, 1'b0); #1; check_fixed("rstbusy1", 1'b1, 2'b01, 2'b00, 1'b0);
        $display("txn reset-mid-busy sequence done");

        // Randomized traffic against the ownership model.
        @(negedge clk);
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < NR; i++) begin
            pend[i] = 1'b0; lockr[i] = 1'b0;
            p_addr[i] = '0; p_wdata[i] = '0; p_wstrb[i] = '0; p_write[i] = 1'b0;
        end
        @(negedge clk);
        rst_n   = 1'b1;
        m_owner = -1;
        m_ptr   = 0;

        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (!pend[i]) begin
                    if (lockr[i] && $urandom_range(0, 2) == 0) lockr[i] = 1'b0;
                    if ($urandom_range(0, 1) == 1) begin
                        pend[i]    = 1'b1;
                        tmp        = $urandom;
                        p_addr[i]  = tmp & 32'hFFFF_FFFC;
                        p_wdata[i] = $urandom;
                        tmp        = $urandom;
                        p_wstrb[i] = tmp[3:0];
                        p_write[i] = tmp[4];
                        lockr[i]   = ($urandom_range(0, 3) == 0);
                    end
                end
                req_valid[i]          = pend[i];
                req_lock[i]           = lockr[i];
                req_addr[i*32 +: 32]  = p_addr[i];
                req_wdata[i*32 +: 32] = p_wdata[i];
                req_wstrb[i*4 +: 4]   = p_wstrb[i];
                req_write[i]          = p_write[i];
            end
            dmem_ready = ($urandom_range(0, 2) != 0);
            dmem_err   = ($urandom_range(0, 7) == 0);
            dmem_rdata = $urandom;
            #1;

            sel     = model_sel(req_valid);
            e_dv    = (sel >= 0) && req_valid[sel];
            e_rdy   = '0;
            if (e_dv && dmem_ready) e_rdy[sel] = 1'b1;
            e_err   = dmem_err ? e_rdy : 2'b00;
            e_addr  = e_dv ? p_addr[sel]  : 32'h0;
            e_wdata = e_dv ? p_wdata[sel] : 32'h0;
            e_wstrb = e_dv ? p_wstrb[sel] : 4'h0;
            e_wr    = e_dv ? p_write[sel] : 1'b0;

            check("rnd.dmem_valid", 64'(dmem_valid), 64'(e_dv));
            check("rnd.req_ready",  64'(req_ready),  64'(e_rdy));
            check("rnd.req_err",    64'(req_err),    64'(e_err));
            check("rnd.dmem_addr",  64'(dmem_addr),  64'(e_addr));
            check("rnd.dmem_wdata", 64'(dmem_wdata), 64'(e_wdata));
            check("rnd.dmem_wstrb", 64'(dmem_wstrb), 64'(e_wstrb));
            check("rnd.dmem_write", 64'(dmem_write), 64'(e_wr));
            if (e_dv) check("rnd.gnt_idx", 64'(gnt_idx), 64'(sel));

            if (e_dv && dmem_ready) begin
                $display("txn cyc=%0d req%0d addr=%h write=%0b lock=%0b err=%0b",
                         cyc, sel, p_addr[sel], p_write[sel], req_lock[sel], dmem_err);
                pend[sel] = 1'b0;
                if (req_lock[sel]) begin
                    m_owner = sel;
                end else begin
                    m_owner = -1;
                    m_ptr   = (sel + 1) % NR;
                end
            end else if (e_dv) begin
                m_owner = sel;
            end else if (m_owner >= 0 && !req_lock[m_owner]) begin
                m_ptr   = (m_owner + 1) % NR;
                m_owner = -1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
